// File: rtl/rst_seq_pkg.sv
// Shared state encoding and sizing helpers for the reset sequencer.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

    function automatic int cnt_width(input int hold_cyc, input int gap_cyc);
        int largest;
        largest = (hold_cyc > gap_cyc) ? hold_cyc : gap_cyc;
        return clog2(largest + 1);
    endfunction

endpackage

// File: rtl/rst_req_sync.sv
// One-bit synchroniser chain for an asynchronous active-low reset request.
// A synchronous clear loads zeros, so the request reads as active until refilled.
module rst_req_sync #(
    parameter int NUM_STAGES = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic [NUM_STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (clr) begin
            chain <= '0;
        end else begin
            chain <= {chain[NUM_STAGES-2:0], d};
        end
    end

    assign q = chain[NUM_STAGES-1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// Multi-channel reset sequencer: synchronises reset requests, holds all domains
// in reset for a minimum time, then releases the domain resets one by one.
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int NUM_REQ    = 2,
    parameter int NUM_STAGES = 2,
    parameter int HOLD_CYC   = 16,
    parameter int GAP_CYC    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] rst_req_n,
    input  logic               sw_rst_req,
    input  logic               cause_clr,
    output logic [NUM_CH-1:0]  sync_rst,
    output logic               rst_done,
    output logic [NUM_REQ:0]   rst_cause
);

    localparam int CW   = cnt_width(HOLD_CYC, GAP_CYC);
    localparam int IDX_W = (NUM_CH > 1) ? clog2(NUM_CH) : 1;
    localparam int PW   = clog2(NUM_STAGES + 1);

    localparam logic [CW-1:0]    CNT_MAX   = '1;
    localparam logic [CW-1:0]    HOLD_LAST = CW'((HOLD_CYC >= 2) ? (HOLD_CYC - 2) : 0);
    localparam logic [CW-1:0]    GAP_LAST  = CW'(GAP_CYC - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CH - 1);
    localparam logic [PW-1:0]    PRIME_END = PW'(NUM_STAGES);

    logic [NUM_REQ-1:0] req_sync_n;
    logic [NUM_REQ-1:0] hw_active;
    logic               req_active;
    logic               primed;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_CH-1:0]  sync_rst_q, sync_rst_d;
    logic               done_q, done_d;
    logic [NUM_REQ:0]   cause_q, cause_d;
    logic [PW-1:0]      prime_q;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_sync
        rst_req_sync #(.NUM_STAGES(NUM_STAGES)) u_sync (
            .clk (clk),
            .clr (rst),
            .d   (rst_req_n[i]),
            .q   (req_sync_n[i])
        );
    end

    assign hw_active  = ~req_sync_n;
    assign req_active = (|hw_active) | sw_rst_req;

    // Right after reset the chains still hold their cleared zeros; those
    // self-inflicted requests must hold the outputs low but not be logged as causes.
    assign primed = (prime_q == PRIME_END);

    always_comb begin
        state_d    = state_q;
        cnt_d      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        idx_d      = idx_q;
        sync_rst_d = sync_rst_q;
        done_d     = done_q;
        cause_d    = (cause_clr ? '0 : cause_q) | {sw_rst_req, hw_active & {NUM_REQ{primed}}};

        if (req_active) begin
            state_d    = ST_ASSERT;
            cnt_d      = '0;
            idx_d      = '0;
            sync_rst_d = '0;
            done_d     = 1'b0;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    cnt_d = '0;
                    if (HOLD_CYC <= 1) begin
                        sync_rst_d[0] = 1'b1;
                        if (NUM_CH == 1) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_RELEASE;
                            idx_d   = IDX_W'(1);
                        end
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                // HOLD is entered one edge after the last request, so it ends two counts early.
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_d         = '0;
                        sync_rst_d[0] = 1'b1;
                        if (NUM_CH == 1) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_RELEASE;
                            idx_d   = IDX_W'(1);
                        end
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_d             = '0;
                        sync_rst_d[idx_q] = 1'b1;
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_DONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_ASSERT;
            cnt_q      <= '0;
            idx_q      <= '0;
            sync_rst_q <= '0;
            done_q     <= 1'b0;
            cause_q    <= '0;
            prime_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            sync_rst_q <= sync_rst_d;
            done_q     <= done_d;
            cause_q    <= cause_d;
            if (!primed) prime_q <= prime_q + PW'(1);
        end
    end

    assign sync_rst  = sync_rst_q;
    assign rst_done  = done_q;
    assign rst_cause = cause_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: directed vector table, hand-written corner sequences
// and random traffic, all compared against an edge-numbered reference model.
module tb_rst_seq_ctrl;

    localparam int NUM_CH     = 4;
    localparam int NUM_REQ    = 2;
    localparam int NUM_STAGES = 2;
    localparam int HOLD_CYC   = 16;
    localparam int GAP_CYC    = 8;
    localparam int MAX_EDGES  = 8192;

    logic                clk;
    logic                rst;
    logic [NUM_REQ-1:0]  rst_req_n;
    logic                sw_rst_req;
    logic                cause_clr;
    logic [NUM_CH-1:0]   sync_rst;
    logic                rst_done;
    logic [NUM_REQ:0]    rst_cause;

    rst_seq_ctrl #(
        .NUM_CH     (NUM_CH),
        .NUM_REQ    (NUM_REQ),
        .NUM_STAGES (NUM_STAGES),
        .HOLD_CYC   (HOLD_CYC),
        .GAP_CYC    (GAP_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rst_req_n  (rst_req_n),
        .sw_rst_req (sw_rst_req),
        .cause_clr  (cause_clr),
        .sync_rst   (sync_rst),
        .rst_done   (rst_done),
        .rst_cause  (rst_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic               rst;
        logic [NUM_REQ-1:0] req_n;
        logic               sw;
        logic               clr;
        int                 n;
        logic [NUM_CH-1:0]  sync;
        logic               done;
        logic [NUM_REQ:0]   cause;
    } vec_t;

    vec_t vecs[$];

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n   = 0;

    // Reference model: everything follows from the last edge a request was seen.
    logic [NUM_REQ-1:0] hist [MAX_EDGES];
    int                 rst_edge = 0;
    int                 last_act = 0;
    logic [NUM_REQ:0]   m_cause  = '0;
    logic [NUM_CH-1:0]  m_sync   = '0;
    logic               m_done   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, edge_n - 1, act, exp);
        end
    endtask

    task automatic model_edge();
        int                 e;
        logic               primed;
        logic [NUM_REQ-1:0] act_hw;
        e = edge_n;
        hist[e] = rst_req_n;
        if (rst) begin
            rst_edge = e;
            last_act = e;
            m_cause  = '0;
        end else begin
            primed = (e - NUM_STAGES > rst_edge);
            act_hw = primed ? ~hist[e - NUM_STAGES] : '1;
            if ((|act_hw) || sw_rst_req) last_act = e;
            m_cause = (cause_clr ? '0 : m_cause) | {sw_rst_req, primed ? act_hw : '0};
        end
        for (int k = 0; k < NUM_CH; k++) begin
            m_sync[k] = (e >= last_act + HOLD_CYC + k * GAP_CYC);
        end
        m_done = m_sync[NUM_CH-1];
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        edge_n++;
        #1;
        check("model sync_rst", 32'(sync_rst), 32'(m_sync));
        check("model rst_done", 32'(rst_done), 32'(m_done));
        check("model rst_cause", 32'(rst_cause), 32'(m_cause));
    endtask

    task automatic applyStimulus(input logic r, input logic [NUM_REQ-1:0] q, input logic s, input logic c, input int n);
        rst        = r;
        rst_req_n  = q;
        sw_rst_req = s;
        cause_clr  = c;
        repeat (n) step();
    endtask

    task automatic checkOutput(input string name, input logic [NUM_CH-1:0] s, input logic d, input logic [NUM_REQ:0] c);
        check({name, " sync_rst"}, 32'(sync_rst), 32'(s));
        check({name, " rst_done"}, 32'(rst_done), 32'(d));
        check({name, " rst_cause"}, 32'(rst_cause), 32'(c));
    endtask

    task automatic add(input logic r, input logic [1:0] q, input logic s, input logic c, input int n,
                       input logic [3:0] es, input logic ed, input logic [2:0] ec);
        vecs.push_back('{r, q, s, c, n, es, ed, ec});
    endtask

    initial begin
        int low_cnt [NUM_REQ];

        rst        = 1'b1;
        rst_req_n  = '1;
        sw_rst_req = 1'b0;
        cause_clr  = 1'b0;

        // power-up release ladder
        add(1, 2'b11, 0, 0,  1, 4'b0000, 0, 3'b000);
        add(0, 2'b11, 0, 0, 17, 4'b0000, 0, 3'b000);
        add(0, 2'b11, 0, 0,  1, 4'b0001, 0, 3'b000);
        add(0, 2'b11, 0, 0,  8, 4'b0011, 0, 3'b000);
        add(0, 2'b11, 0, 0,  8, 4'b0111, 0, 3'b000);
        add(0, 2'b11, 0, 0,  7, 4'b0111, 0, 3'b000);
        add(0, 2'b11, 0, 0,  1, 4'b1111, 1, 3'b000);
        // async request 1 held low for edges 100..104
        add(0, 2'b11, 0, 0, 57, 4'b1111, 1, 3'b000);
        add(0, 2'b01, 0, 0,  2, 4'b1111, 1, 3'b000);
        add(0, 2'b01, 0, 0,  1, 4'b0000, 0, 3'b010);
        add(0, 2'b01, 0, 0,  2, 4'b0000, 0, 3'b010);
        add(0, 2'b11, 0, 0, 17, 4'b0000, 0, 3'b010);
        add(0, 2'b11, 0, 0,  1, 4'b0001, 0, 3'b010);
        add(0, 2'b11, 0, 0, 23, 4'b0111, 0, 3'b010);
        add(0, 2'b11, 0, 0,  1, 4'b1111, 1, 3'b010);
        // one-cycle request 0 sets up a partial release, then clear, then SW pulse at 200
        add(0, 2'b11, 0, 0, 21, 4'b1111, 1, 3'b010);
        add(0, 2'b10, 0, 0,  1, 4'b1111, 1, 3'b010);
        add(0, 2'b11, 0, 0,  1, 4'b1111, 1, 3'b010);
        add(0, 2'b11, 0, 0,  1, 4'b0000, 0, 3'b011);
        add(0, 2'b11, 0, 0, 19, 4'b0001, 0, 3'b011);
        add(0, 2'b11, 0, 1,  1, 4'b0001, 0, 3'b000);
        add(0, 2'b11, 0, 0,  9, 4'b0011, 0, 3'b000);
        add(0, 2'b11, 1, 0,  1, 4'b0000, 0, 3'b100);
        add(0, 2'b11, 0, 0, 15, 4'b0000, 0, 3'b100);
        add(0, 2'b11, 0, 0,  1, 4'b0001, 0, 3'b100);
        // clear and SW together: set wins; clear alone empties
        add(0, 2'b11, 0, 0,  3, 4'b0001, 0, 3'b100);
        add(0, 2'b11, 1, 1,  1, 4'b0000, 0, 3'b100);
        add(0, 2'b11, 0, 1,  1, 4'b0000, 0, 3'b000);
        add(0, 2'b11, 0, 0, 15, 4'b0001, 0, 3'b000);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].req_n, vecs[i].sw, vecs[i].clr, vecs[i].n);
            checkOutput($sformatf("vec%0d", i), vecs[i].sync, vecs[i].done, vecs[i].cause);
        end

        // request re-asserted ten edges into the hold phase restarts the timer
        applyStimulus(0, 2'b11, 0, 0, 3);
        applyStimulus(0, 2'b11, 1, 0, 1);
        checkOutput("hold_first", 4'b0000, 0, 3'b100);
        applyStimulus(0, 2'b11, 0, 0, 10);
        applyStimulus(0, 2'b11, 1, 0, 1);
        applyStimulus(0, 2'b11, 0, 0, 5);
        checkOutput("hold_no_early", 4'b0000, 0, 3'b100);
        applyStimulus(0, 2'b11, 0, 0, 10);
        checkOutput("hold_pre", 4'b0000, 0, 3'b100);
        applyStimulus(0, 2'b11, 0, 0, 1);
        checkOutput("hold_rel", 4'b0001, 0, 3'b100);

        // block reset in the middle of the release ladder
        applyStimulus(0, 2'b11, 0, 0, 12);
        checkOutput("mid_release", 4'b0011, 0, 3'b100);
        applyStimulus(1, 2'b11, 0, 0, 1);
        checkOutput("rst_mid", 4'b0000, 0, 3'b000);
        applyStimulus(0, 2'b11, 0, 0, 17);
        checkOutput("rst_hold", 4'b0000, 0, 3'b000);
        applyStimulus(0, 2'b11, 0, 0, 1);
        checkOutput("rst_ch0", 4'b0001, 0, 3'b000);
        applyStimulus(0, 2'b11, 0, 0, 23);
        checkOutput("rst_pre_done", 4'b0111, 0, 3'b000);
        applyStimulus(0, 2'b11, 0, 0, 1);
        checkOutput("rst_done", 4'b1111, 1, 3'b000);

        // random traffic against the model
        foreach (low_cnt[b]) low_cnt[b] = 0;
        for (int c = 0; c < 2500; c++) begin
            for (int b = 0; b < NUM_REQ; b++) begin
                if (low_cnt[b] == 0 && $urandom_range(0, 199) == 0) low_cnt[b] = $urandom_range(1, 4);
                rst_req_n[b] = (low_cnt[b] == 0);
                if (low_cnt[b] > 0) low_cnt[b]--;
            end
            sw_rst_req = ($urandom_range(0, 299) == 0);
            cause_clr  = ($urandom_range(0, 49) == 0);
            rst        = ($urandom_range(0, 999) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
